// File: rtl/dma_arbiter_if.sv
// +-----------------------------------------------------------------------------
// | dma_arbiter_if : requester / DMA-controller / status bundle for dma_arbiter
// | Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

interface dma_arbiter_if #(
  parameter int NDEV     = 4,
  parameter int ADD_LEN  = 16,
  parameter int DATA_LEN = 16
);
  localparam int OW = (NDEV > 1) ? $clog2(NDEV) : 1;

  // requester side
  logic [NDEV-1:0]            req;
  logic [NDEV-1:0]            req_rd_wr;
  logic [NDEV*ADD_LEN-1:0]    req_num_words;
  logic [NDEV*(ADD_LEN+1)-1:0] req_start_addr;
  logic [NDEV-1:0]            req_dev_ack;
  logic [NDEV*DATA_LEN-1:0]   req_dev_in;
  logic [NDEV-1:0]            grant;
  logic [NDEV-1:0]            req_dma_ack;
  logic [NDEV-1:0]            req_end;

  // DMA controller side
  logic                       dma_rqst;
  logic                       dma_rd_wr;
  logic [ADD_LEN-1:0]         dma_num_words;
  logic [ADD_LEN:0]           dma_start_addr;
  logic                       dma_dev_ack;
  logic [DATA_LEN-1:0]        dma_dev_in;
  logic                       dma_ack;
  logic                       dma_end_flag;

  // status
  logic                       busy;
  logic [OW-1:0]              owner_id;
  logic                       wd_timeout;

  modport master (
    input  req, req_rd_wr, req_num_words, req_start_addr, req_dev_ack, req_dev_in,
    input  dma_ack, dma_end_flag,
    output grant, req_dma_ack, req_end,
    output dma_rqst, dma_rd_wr, dma_num_words, dma_start_addr, dma_dev_ack, dma_dev_in,
    output busy, owner_id, wd_timeout
  );

  modport slave (
    output req, req_rd_wr, req_num_words, req_start_addr, req_dev_ack, req_dev_in,
    output dma_ack, dma_end_flag,
    input  grant, req_dma_ack, req_end,
    input  dma_rqst, dma_rd_wr, dma_num_words, dma_start_addr, dma_dev_ack, dma_dev_in,
    input  busy, owner_id, wd_timeout
  );
endinterface

`default_nettype wire

// File: rtl/dma_arbiter.sv
// +-----------------------------------------------------------------------------
// | dma_arbiter : round-robin arbiter sharing one DMA controller among NDEV devices
// | Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module dma_arbiter #(
  parameter int NDEV     = 4,
  parameter int ADD_LEN  = 16,
  parameter int DATA_LEN = 16,
  parameter int WD_LEN   = 12
) (
  input  wire logic      clk,
  input  wire logic      reset,
  dma_arbiter_if.master  bus
);
  localparam int OW = (NDEV > 1) ? $clog2(NDEV) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_BUSY   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_COOL   = 3'd5;

  logic [2:0]          r_state;
  logic [OW-1:0]       r_rr_ptr;
  logic [OW-1:0]       r_owner;
  logic [NDEV-1:0]     r_grant;
  logic                r_rd_wr;
  logic [ADD_LEN-1:0]  r_num_words;
  logic [ADD_LEN:0]    r_start_addr;
  logic [WD_LEN-1:0]   r_wd;
  logic                r_wd_to;

  logic                w_found;
  logic [OW-1:0]       w_pick;
  logic                w_active;
  logic [WD_LEN-1:0]   w_wd_next;
  logic [OW-1:0]       w_rr_next;
  logic [NDEV-1:0]     w_req_dma_ack;

  // First asserted request at or after r_rr_ptr, wrapping past NDEV-1.
  always_comb begin : p_pick
    int j;
    w_found = 1'b0;
    w_pick  = '0;
    j       = 0;
    for (int k = 0; k < NDEV; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NDEV) j = j - NDEV;
      if (!w_found && bus.req[j[OW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = j[OW-1:0];
      end
    end
  end

  assign w_active  = (r_state == S_LAUNCH) || (r_state == S_BUSY) || (r_state == S_DONE);
  assign w_wd_next = (&r_wd) ? r_wd : r_wd + 1'b1;
  assign w_rr_next = (int'(r_owner) == NDEV - 1) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_grant      <= '0;
      r_rd_wr      <= 1'b0;
      r_num_words  <= '0;
      r_start_addr <= '0;
      r_wd         <= '0;
      r_wd_to      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_found) begin
            r_owner         <= w_pick;
            r_grant         <= '0;
            r_grant[w_pick] <= 1'b1;
            r_rd_wr         <= bus.req_rd_wr[w_pick];
            r_num_words     <= bus.req_num_words[int'(w_pick)*ADD_LEN +: ADD_LEN];
            r_start_addr    <= bus.req_start_addr[int'(w_pick)*(ADD_LEN+1) +: ADD_LEN+1];
            r_state         <= S_LAUNCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          r_wd    <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          // The watchdog only flags; the transfer still waits for the controller.
          r_wd <= w_wd_next;
          if (&w_wd_next) r_wd_to <= 1'b1;
          if (bus.dma_end_flag) r_state <= S_DONE;
        end
        S_DONE: begin
          r_rr_ptr <= w_rr_next;
          r_grant  <= '0;
          r_state  <= S_COOL;
        end
        S_COOL: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_req_dma_ack = '0;
    if (w_active) w_req_dma_ack[r_owner] = bus.dma_ack;
  end

  assign bus.grant          = r_grant;
  assign bus.req_dma_ack    = w_req_dma_ack;
  assign bus.req_end        = (r_state == S_DONE) ? r_grant : '0;
  assign bus.dma_rqst       = (r_state == S_LAUNCH);
  assign bus.dma_rd_wr      = w_active & r_rd_wr;
  assign bus.dma_num_words  = w_active ? r_num_words : '0;
  assign bus.dma_start_addr = w_active ? r_start_addr : '0;
  assign bus.dma_dev_ack    = w_active & bus.req_dev_ack[r_owner];
  assign bus.dma_dev_in     = w_active ? bus.req_dev_in[int'(r_owner)*DATA_LEN +: DATA_LEN] : '0;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.owner_id       = r_owner;
  assign bus.wd_timeout     = r_wd_to;

endmodule

`default_nettype wire

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: a transaction-level reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
`default_nettype none

module tb_dma_arbiter;
  localparam int NDEV = 4;
  localparam int AL   = 16;
  localparam int DL   = 16;
  localparam int WD   = 4;
  localparam int WMAX = (1 << WD) - 1;

  localparam int PH_IDLE = 0, PH_PICK = 1, PH_GO = 2, PH_XFER = 3, PH_END = 4, PH_REST = 5;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   rq_log[$];

  dma_arbiter_if #(.NDEV(NDEV), .ADD_LEN(AL), .DATA_LEN(DL)) bus ();

  dma_arbiter #(.NDEV(NDEV), .ADD_LEN(AL), .DATA_LEN(DL), .WD_LEN(WD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: where the current transfer is, who owns it, and what was captured.
  int ph, m_own, m_ptr, m_nw, m_sa, m_wd;
  bit m_rw, m_to;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = PH_IDLE; m_own = 0; m_ptr = 0; m_rw = 0; m_nw = 0; m_sa = 0; m_wd = 0; m_to = 0;
    end else begin
      case (ph)
        PH_IDLE: if (bus.req != 0) ph = PH_PICK;
        PH_PICK: begin
          ph = PH_IDLE;
          for (int k = 0; k < NDEV; k++) begin
            if (ph == PH_IDLE && bus.req[(m_ptr + k) % NDEV]) begin
              m_own = (m_ptr + k) % NDEV;
              m_rw  = bus.req_rd_wr[m_own];
              m_nw  = int'(bus.req_num_words[m_own*AL +: AL]);
              m_sa  = int'(bus.req_start_addr[m_own*(AL+1) +: AL+1]);
              ph    = PH_GO;
            end
          end
        end
        PH_GO: begin m_wd = 0; ph = PH_XFER; end
        PH_XFER: begin
          if (m_wd < WMAX) m_wd = m_wd + 1;
          if (m_wd == WMAX) m_to = 1;
          if (bus.dma_end_flag) ph = PH_END;
        end
        PH_END: begin m_ptr = (m_own + 1) % NDEV; ph = PH_REST; end
        default: ph = PH_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    bit act;
    act = (ph == PH_GO) || (ph == PH_XFER) || (ph == PH_END);
    chk("m_busy",     bus.busy, ph != PH_IDLE);
    chk("m_grant",    bus.grant, act ? (64'd1 << m_own) : 64'd0);
    chk("m_owner",    bus.owner_id, m_own);
    chk("m_rqst",     bus.dma_rqst, ph == PH_GO);
    chk("m_rdwr",     bus.dma_rd_wr, act ? m_rw : 1'b0);
    chk("m_nw",       bus.dma_num_words, act ? m_nw : 0);
    chk("m_sa",       bus.dma_start_addr, act ? m_sa : 0);
    chk("m_devack",   bus.dma_dev_ack, act ? bus.req_dev_ack[m_own] : 1'b0);
    chk("m_devin",    bus.dma_dev_in, act ? bus.req_dev_in[m_own*DL +: DL] : 0);
    chk("m_reqdmaack", bus.req_dma_ack, (act && bus.dma_ack) ? (64'd1 << m_own) : 64'd0);
    chk("m_reqend",   bus.req_end, (ph == PH_END) ? (64'd1 << m_own) : 64'd0);
    chk("m_wdto",     bus.wd_timeout, m_to);
    if (bus.dma_rqst === 1'b1) rq_log.push_back(int'(bus.owner_id));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rqst(input string nm);
    int i;
    i = 0;
    while (bus.dma_rqst !== 1'b1 && i < 20) begin
      tick(1);
      i++;
    end
    chk(nm, bus.dma_rqst, 1);
  endtask

  task automatic end_xfer();
    bus.dma_end_flag = 1'b1;
    tick(1);
    bus.dma_end_flag = 1'b0;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int n0;

  initial begin
    bus.req = '0; bus.req_rd_wr = '0; bus.req_num_words = '0; bus.req_start_addr = '0;
    bus.req_dev_ack = '0; bus.req_dev_in = '0; bus.dma_ack = 1'b0; bus.dma_end_flag = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_wdto", bus.wd_timeout, 0);
    tick(2);
    reset = 1'b1;
    tick(1);

    // single requester
    bus.req_num_words[0 +: AL] = 16'd4;
    bus.req_start_addr[0 +: AL+1] = 17'h0200;
    bus.req_rd_wr[0] = 1'b1;
    bus.req = 4'b0001;
    tick(1);
    chk("t1_arb_grant", bus.grant, 0);
    chk("t1_arb_busy", bus.busy, 1);
    tick(1);
    chk("t1_rqst", bus.dma_rqst, 1);
    chk("t1_addr", bus.dma_start_addr, 17'h0200);
    chk("t1_nw", bus.dma_num_words, 4);
    chk("t1_rw", bus.dma_rd_wr, 1);
    chk("t1_grant", bus.grant, 4'b0001);
    bus.req = 4'b0000;
    tick(1);
    chk("t1_rqst_once", bus.dma_rqst, 0);
    chk("t1_grant_held", bus.grant, 4'b0001);
    tick(2);
    end_xfer();
    chk("t1_end", bus.req_end, 4'b0001);
    chk("t1_done_addr", bus.dma_start_addr, 17'h0200);
    tick(1);
    chk("t1_cool_grant", bus.grant, 0);
    chk("t1_cool_busy", bus.busy, 1);
    chk("t1_cool_end", bus.req_end, 0);
    tick(1);
    chk("t1_idle", bus.busy, 0);

    // reset mid-BUSY (pointer is 1 here)
    bus.req_num_words[2*AL +: AL] = 16'd8;
    bus.req_start_addr[2*(AL+1) +: AL+1] = 17'h0300;
    bus.req = 4'b0100;
    wait_rqst("tr_rqst");
    tick(2);
    chk("tr_owner", bus.owner_id, 2);
    #1 reset = 1'b0;
    #1;
    chk("tr_grant", bus.grant, 0);
    chk("tr_busy", bus.busy, 0);
    chk("tr_addr", bus.dma_start_addr, 0);
    chk("tr_end", bus.req_end, 0);
    bus.req = 4'b0000;
    tick(1);
    reset = 1'b1;
    tick(2);

    // all requesting: round-robin from pointer 0
    for (int k = 0; k < NDEV; k++) begin
      bus.req_num_words[k*AL +: AL] = AL'(k + 1);
      bus.req_start_addr[k*(AL+1) +: AL+1] = (AL+1)'(17'h1000 + 17'(k * 16));
    end
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_rqst("t2_rqst");
      chk("t2_owner", bus.owner_id, exp_order[i]);
      tick(1);
      end_xfer();
      chk("t2_end", bus.req_end, 64'd1 << exp_order[i]);
      tick(1);
      chk("t2_cool_grant", bus.grant, 0);
      chk("t2_cool_rqst", bus.dma_rqst, 0);
    end
    bus.req = 4'b0000;
    tick(3);

    // routing through owner 2
    bus.req_dev_in[2*DL +: DL] = 16'hBEEF;
    bus.req_dev_in[1*DL +: DL] = 16'h1234;
    bus.req_dev_ack = 4'b0010;
    bus.req = 4'b0100;
    wait_rqst("t3_rqst");
    chk("t3_owner", bus.owner_id, 2);
    bus.req = 4'b0000;
    tick(1);
    chk("t3_devack_other", bus.dma_dev_ack, 0);
    chk("t3_devin", bus.dma_dev_in, 16'hBEEF);
    bus.req_dev_ack = 4'b0100;
    #1 chk("t3_devack", bus.dma_dev_ack, 1);
    bus.dma_ack = 1'b1;
    #1 chk("t3_reqdmaack", bus.req_dma_ack, 4'b0100);
    tick(1);
    bus.req_dev_ack = 4'b0000;
    bus.dma_ack = 1'b0;
    #1 chk("t3_devack_off", bus.dma_dev_ack, 0);
    chk("t3_reqdmaack_off", bus.req_dma_ack, 0);
    end_xfer();
    tick(2);

    // watchdog
    bus.req_num_words[3*AL +: AL] = 16'd5;
    bus.req = 4'b1000;
    wait_rqst("t4_rqst");
    bus.req = 4'b0000;
    tick(1);
    tick(14);
    chk("t4_wd_before", bus.wd_timeout, 0);
    tick(1);
    chk("t4_wd_set", bus.wd_timeout, 1);
    chk("t4_busy", bus.busy, 1);
    tick(3);
    chk("t4_still_grant", bus.grant, 4'b1000);
    end_xfer();
    chk("t4_end", bus.req_end, 4'b1000);
    tick(2);
    chk("t4_idle", bus.busy, 0);
    chk("t4_wd_sticky", bus.wd_timeout, 1);
    bus.dma_end_flag = 1'b1;
    tick(2);
    chk("t4_endflag_ignored", bus.busy, 0);
    bus.dma_end_flag = 1'b0;

    // withdrawal
    n0 = rq_log.size();
    bus.req = 4'b0001;
    tick(1);
    bus.req = 4'b0000;
    chk("t5_arb", bus.busy, 1);
    tick(1);
    chk("t5_idle", bus.busy, 0);
    chk("t5_grant", bus.grant, 0);
    tick(3);
    chk("t5_no_rqst", rq_log.size(), n0);

    // zero-length transfer (pointer 0, only device 1 asks)
    bus.req_num_words[1*AL +: AL] = 16'd0;
    bus.req_start_addr[1*(AL+1) +: AL+1] = 17'h0400;
    bus.req = 4'b0010;
    wait_rqst("t6_rqst");
    chk("t6_nw", bus.dma_num_words, 0);
    chk("t6_addr", bus.dma_start_addr, 17'h0400);
    bus.req = 4'b0000;
    tick(1);
    end_xfer();
    chk("t6_end", bus.req_end, 4'b0010);
    tick(2);
    chk("t6_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
